// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction-fetch stage.
// Holds the PC and the IF/ID pipeline register, and applies load-use
// stalls and taken-branch redirects. It also keeps fetch statistics.
// Priority on each edge: reset, then redirect, then stall, then normal fetch.
module fetch_stage #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stall,
   input  logic             i_branch_taken,
   input  logic [WIDTH-1:0] i_branch_target,
   output logic [WIDTH-1:0] o_imem_addr,
   input  logic [WIDTH-1:0] i_imem_data,
   output logic [WIDTH-1:0] o_ifid_pc,
   output logic [WIDTH-1:0] o_ifid_pc_plus4,
   output logic [WIDTH-1:0] o_ifid_instr,
   output logic             o_ifid_valid,
   output logic             o_misalign_err,
   output logic [31:0]      o_fetch_count,
   output logic [31:0]      o_stall_count,
   output logic [31:0]      o_flush_count
);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_ifid_pc;
   logic [WIDTH-1:0] r_ifid_pc_plus4;
   logic [WIDTH-1:0] r_ifid_instr;
   logic             r_ifid_valid;
   logic             r_misalign_err;
   logic [31:0]      r_fetch_count;
   logic [31:0]      r_stall_count;
   logic [31:0]      r_flush_count;
   logic [WIDTH-1:0] w_pc_plus4;
   logic [WIDTH-1:0] w_redirect_pc;
   logic             w_target_misaligned;

   // Next sequential PC and the word-aligned redirect address.
   // The low bits of the target are dropped, so a misaligned target still
   // fetches from an aligned word and only raises the sticky error flag.
   always_comb begin
      w_pc_plus4          = r_pc + WIDTH'(4);
      w_redirect_pc       = {i_branch_target[WIDTH-1:2], 2'b00};
      w_target_misaligned = |i_branch_target[1:0];
   end

   // PC, IF/ID register, error flag and counters, with the per-edge priority.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc            <= RESET_PC;
         r_ifid_pc       <= '0;
         r_ifid_pc_plus4 <= '0;
         r_ifid_instr    <= NOP_INSTR;
         r_ifid_valid    <= 1'b0;
         r_misalign_err  <= 1'b0;
         r_fetch_count   <= '0;
         r_stall_count   <= '0;
         r_flush_count   <= '0;
      end else if (i_branch_taken) begin
         // A redirect beats a stall. The word fetched in this cycle is on the
         // wrong path, so a bubble goes into IF/ID and ifid_pc is left alone.
         r_pc          <= w_redirect_pc;
         r_ifid_instr  <= NOP_INSTR;
         r_ifid_valid  <= 1'b0;
         r_flush_count <= r_flush_count + 32'd1;
         if (w_target_misaligned) begin
            r_misalign_err <= 1'b1;
         end
      end else if (i_stall) begin
         r_stall_count <= r_stall_count + 32'd1;
      end else begin
         r_ifid_pc       <= r_pc;
         r_ifid_pc_plus4 <= w_pc_plus4;
         r_ifid_instr    <= i_imem_data;
         r_ifid_valid    <= 1'b1;
         r_pc            <= w_pc_plus4;
         r_fetch_count   <= r_fetch_count + 32'd1;
      end
   end

   // Outputs are taken straight from the registers.
   always_comb begin
      o_imem_addr     = r_pc;
      o_ifid_pc       = r_ifid_pc;
      o_ifid_pc_plus4 = r_ifid_pc_plus4;
      o_ifid_instr    = r_ifid_instr;
      o_ifid_valid    = r_ifid_valid;
      o_misalign_err  = r_misalign_err;
      o_fetch_count   = r_fetch_count;
      o_stall_count   = r_stall_count;
      o_flush_count   = r_flush_count;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios and a randomized run for fetch_stage.
// The randomized run is checked against a behavioural pipeline model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        r_clk = 1'b0;
   logic        r_rst;
   logic        r_stall;
   logic        r_bt;
   logic [31:0] r_target;
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_data;
   logic [31:0] w_ifid_pc;
   logic [31:0] w_ifid_pc_plus4;
   logic [31:0] w_ifid_instr;
   logic        w_ifid_valid;
   logic        w_mis;
   logic [31:0] w_fetch_count;
   logic [31:0] w_stall_count;
   logic [31:0] w_flush_count;

   logic [31:0] mem [256];

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural view of the stage: what the pipeline should hold after each edge.
   logic [31:0] m_pc, m_ifid_pc, m_ifid_p4, m_instr;
   logic        m_valid, m_mis;
   logic [31:0] m_fetch, m_stall, m_flush;

   always #5 r_clk = ~r_clk;

   // Memory is combinational and returns a NOP while reset is asserted.
   assign w_imem_data = r_rst ? NOP : mem[w_imem_addr[9:2]];

   fetch_stage dut (
      .i_clk           (r_clk),
      .i_rst           (r_rst),
      .i_stall         (r_stall),
      .i_branch_taken  (r_bt),
      .i_branch_target (r_target),
      .o_imem_addr     (w_imem_addr),
      .i_imem_data     (w_imem_data),
      .o_ifid_pc       (w_ifid_pc),
      .o_ifid_pc_plus4 (w_ifid_pc_plus4),
      .o_ifid_instr    (w_ifid_instr),
      .o_ifid_valid    (w_ifid_valid),
      .o_misalign_err  (w_mis),
      .o_fetch_count   (w_fetch_count),
      .o_stall_count   (w_stall_count),
      .o_flush_count   (w_flush_count)
   );

   // Advance the model by one clock, given the inputs in force at that edge.
   task automatic model_edge(input logic rst, input logic stall, input logic bt, input logic [31:0] tgt);
      if (rst) begin
         m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_p4 = 32'h0; m_instr = NOP;
         m_valid = 1'b0; m_mis = 1'b0; m_fetch = 0; m_stall = 0; m_flush = 0;
      end else if (bt) begin
         m_pc = tgt & 32'hFFFF_FFFC;
         m_instr = NOP; m_valid = 1'b0; m_flush = m_flush + 1;
         if (tgt % 4 != 0) m_mis = 1'b1;
      end else if (stall) begin
         m_stall = m_stall + 1;
      end else begin
         m_ifid_pc = m_pc; m_ifid_p4 = m_pc + 4; m_instr = mem[m_pc[9:2]];
         m_valid = 1'b1; m_pc = m_pc + 4; m_fetch = m_fetch + 1;
      end
   endtask

   // Apply inputs, clock once, and sample 1 time unit after the rising edge.
   task automatic tick(input logic rst, input logic stall, input logic bt, input logic [31:0] tgt);
      r_rst = rst; r_stall = stall; r_bt = bt; r_target = tgt;
      @(posedge r_clk);
      #1;
      model_edge(rst, stall, bt, tgt);
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 32'h0);
      tick(1, 1, 1, 32'h0000_0044);
      n_cmp++; if (w_imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h exp %h", w_imem_addr, 32'h0); end
      n_cmp++; if (w_ifid_instr !== NOP) begin n_bad++; $display("FAIL reset_instr got %h exp %h", w_ifid_instr, NOP); end
      n_cmp++; if (w_ifid_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", w_ifid_valid); end
      n_cmp++; if (w_ifid_pc !== 32'h0 || w_ifid_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL reset_ifid_pc got %h/%h exp 0/0", w_ifid_pc, w_ifid_pc_plus4); end
      n_cmp++; if (w_mis !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %b exp 0", w_mis); end
      n_cmp++; if (w_fetch_count !== 0 || w_stall_count !== 0 || w_flush_count !== 0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d/%0d exp 0/0/0", w_fetch_count, w_stall_count, w_flush_count); end
   endtask

   task automatic test_free_run();
      tick(0, 0, 0, 32'h0);
      n_cmp++; if (w_imem_addr !== 32'h4) begin n_bad++; $display("FAIL run1_addr got %h exp 4", w_imem_addr); end
      n_cmp++; if (w_ifid_pc !== 32'h0 || w_ifid_instr !== 32'h00A0_0093 || w_ifid_valid !== 1'b1 || w_ifid_pc_plus4 !== 32'h4) begin
         n_bad++; $display("FAIL run1_ifid got pc=%h instr=%h v=%b p4=%h exp 0/00a00093/1/4", w_ifid_pc, w_ifid_instr, w_ifid_valid, w_ifid_pc_plus4); end
      tick(0, 0, 0, 32'h0);
      n_cmp++; if (w_imem_addr !== 32'h8) begin n_bad++; $display("FAIL run2_addr got %h exp 8", w_imem_addr); end
      n_cmp++; if (w_ifid_pc !== 32'h4 || w_ifid_instr !== 32'h0050_8133 || w_ifid_pc_plus4 !== 32'h8) begin
         n_bad++; $display("FAIL run2_ifid got pc=%h instr=%h p4=%h exp 4/00508133/8", w_ifid_pc, w_ifid_instr, w_ifid_pc_plus4); end
   endtask

   task automatic test_stall();
      tick(0, 1, 0, 32'h0);
      n_cmp++; if (w_imem_addr !== 32'h8 || w_ifid_pc !== 32'h4 || w_ifid_instr !== 32'h0050_8133) begin
         n_bad++; $display("FAIL stall_hold got addr=%h pc=%h instr=%h exp 8/4/00508133", w_imem_addr, w_ifid_pc, w_ifid_instr); end
      n_cmp++; if (w_stall_count !== 32'd1 || w_fetch_count !== 32'd2) begin n_bad++; $display("FAIL stall_counts got %0d/%0d exp 1/2", w_stall_count, w_fetch_count); end
      tick(0, 0, 0, 32'h0);
      n_cmp++; if (w_ifid_pc !== 32'h8 || w_ifid_instr !== 32'h0001_01B3 || w_ifid_pc_plus4 !== 32'hC || w_imem_addr !== 32'hC) begin
         n_bad++; $display("FAIL stall_resume got pc=%h instr=%h p4=%h addr=%h exp 8/000101b3/c/c", w_ifid_pc, w_ifid_instr, w_ifid_pc_plus4, w_imem_addr); end
      n_cmp++; if (w_fetch_count !== 32'd3) begin n_bad++; $display("FAIL fetch_count3 got %0d exp 3", w_fetch_count); end
   endtask

   task automatic test_redirect();
      tick(1, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      tick(0, 0, 1, 32'h0000_000C);
      n_cmp++; if (w_imem_addr !== 32'hC || w_ifid_valid !== 1'b0 || w_ifid_instr !== NOP) begin
         n_bad++; $display("FAIL redir_bubble got addr=%h v=%b instr=%h exp c/0/00000013", w_imem_addr, w_ifid_valid, w_ifid_instr); end
      n_cmp++; if (w_flush_count !== 32'd1 || w_ifid_pc !== 32'h4) begin n_bad++; $display("FAIL redir_flush got flush=%0d pc=%h exp 1/4", w_flush_count, w_ifid_pc); end
      tick(0, 0, 0, 32'h0);
      n_cmp++; if (w_ifid_pc !== 32'hC || w_ifid_valid !== 1'b1 || w_ifid_instr !== mem[3]) begin
         n_bad++; $display("FAIL redir_target got pc=%h v=%b instr=%h exp c/1/%h", w_ifid_pc, w_ifid_valid, w_ifid_instr, mem[3]); end
   endtask

   task automatic test_collision();
      logic [31:0] sc, fc;
      sc = w_stall_count; fc = w_flush_count;
      tick(0, 1, 1, 32'h0000_0040);
      n_cmp++; if (w_imem_addr !== 32'h40 || w_ifid_valid !== 1'b0 || w_ifid_instr !== NOP) begin
         n_bad++; $display("FAIL coll_redir got addr=%h v=%b instr=%h exp 40/0/00000013", w_imem_addr, w_ifid_valid, w_ifid_instr); end
      n_cmp++; if (w_stall_count !== sc || w_flush_count !== fc + 1) begin
         n_bad++; $display("FAIL coll_counts got stall=%0d flush=%0d exp %0d/%0d", w_stall_count, w_flush_count, sc, fc + 1); end
   endtask

   task automatic test_misalign();
      tick(0, 0, 1, 32'h0000_0016);
      n_cmp++; if (w_imem_addr !== 32'h14 || w_mis !== 1'b1) begin n_bad++; $display("FAIL mis_set got addr=%h mis=%b exp 14/1", w_imem_addr, w_mis); end
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 32'h0);
      n_cmp++; if (w_mis !== 1'b1 || w_imem_addr !== 32'h20) begin n_bad++; $display("FAIL mis_sticky got mis=%b addr=%h exp 1/20", w_mis, w_imem_addr); end
      n_cmp++; if (w_ifid_pc !== 32'h1C || w_ifid_instr !== mem[7]) begin n_bad++; $display("FAIL mis_fetch got pc=%h instr=%h exp 1c/%h", w_ifid_pc, w_ifid_instr, mem[7]); end
   endtask

   task automatic test_reset_mid();
      tick(1, 1, 0, 32'h0);
      n_cmp++; if (w_imem_addr !== 32'h0 || w_ifid_valid !== 1'b0 || w_mis !== 1'b0) begin
         n_bad++; $display("FAIL midrst_state got addr=%h v=%b mis=%b exp 0/0/0", w_imem_addr, w_ifid_valid, w_mis); end
      n_cmp++; if (w_fetch_count !== 0 || w_stall_count !== 0 || w_flush_count !== 0) begin
         n_bad++; $display("FAIL midrst_counts got %0d/%0d/%0d exp 0/0/0", w_fetch_count, w_stall_count, w_flush_count); end
      tick(0, 0, 0, 32'h0);
      n_cmp++; if (w_ifid_pc !== 32'h0 || w_ifid_instr !== 32'h00A0_0093 || w_imem_addr !== 32'h4) begin
         n_bad++; $display("FAIL midrst_first got pc=%h instr=%h addr=%h exp 0/00a00093/4", w_ifid_pc, w_ifid_instr, w_imem_addr); end
   endtask

   task automatic test_random();
      logic rst, stall, bt;
      logic [31:0] tgt;
      tick(1, 0, 0, 32'h0);
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 59) == 0);
         stall = ($urandom_range(0, 3) == 0);
         bt    = ($urandom_range(0, 6) == 0);
         tgt   = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 1023));
         tick(rst, stall, bt, tgt);
         n_cmp++; if (w_imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", c, w_imem_addr, m_pc); end
         n_cmp++; if (w_ifid_pc !== m_ifid_pc || w_ifid_pc_plus4 !== m_ifid_p4) begin
            n_bad++; $display("FAIL rnd_ifid_pc cyc=%0d got %h/%h exp %h/%h", c, w_ifid_pc, w_ifid_pc_plus4, m_ifid_pc, m_ifid_p4); end
         n_cmp++; if (w_ifid_instr !== m_instr || w_ifid_valid !== m_valid) begin
            n_bad++; $display("FAIL rnd_ifid_instr cyc=%0d got %h/%b exp %h/%b", c, w_ifid_instr, w_ifid_valid, m_instr, m_valid); end
         n_cmp++; if (w_mis !== m_mis) begin n_bad++; $display("FAIL rnd_mis cyc=%0d got %b exp %b", c, w_mis, m_mis); end
         n_cmp++; if (w_fetch_count !== m_fetch || w_stall_count !== m_stall || w_flush_count !== m_flush) begin
            n_bad++; $display("FAIL rnd_counts cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, w_fetch_count, w_stall_count, w_flush_count, m_fetch, m_stall, m_flush); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h00A0_0093;
      mem[1] = 32'h0050_8133;
      mem[2] = 32'h0001_01B3;
      r_rst = 1'b1; r_stall = 1'b0; r_bt = 1'b0; r_target = 32'h0;
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_collision();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32 core. Owns the program counter and drives the instruction-memory read address. Captures the returned instruction word into the IF/ID pipeline register. Applies load-use stalls and taken-branch redirects/flushes from the hazard and EX logic, and keeps fetch performance counters.

## Interface
Parameters:
- WIDTH, 32, address/instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) inserted on flush/reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit hold: freeze PC and IF/ID
- branch_taken  in  1  EX-stage taken branch/jump: redirect PC, flush IF/ID
- branch_target  in  WIDTH  redirect address, sampled when branch_taken=1
- imem_addr  out  WIDTH  byte address to instruction memory (equals PC register)
- imem_data  in  WIDTH  instruction word from memory (combinational, same cycle)
- ifid_pc  out  WIDTH  PC of instruction held in IF/ID
- ifid_pc_plus4  out  WIDTH  ifid_pc + 4 (link value)
- ifid_instr  out  WIDTH  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a real (non-bubble) instruction
- misalign_err  out  1  sticky: a redirect target had [1:0] != 0
- fetch_count  out  32  valid instructions loaded into IF/ID
- stall_count  out  32  cycles held by stall
- flush_count  out  32  redirects taken

## Operation
- State: pc, IF/ID register (pc, pc+4, instr, valid), misalign_err, three counters. No FSM beyond the per-cycle priority below.
- imem_addr = pc, purely combinational from the register.
- Per-edge priority, highest first:
  - rst:
    - pc<=RESET_PC, ifid_pc<=0, ifid_pc_plus4<=0, ifid_instr<=NOP_INSTR, ifid_valid<=0
    - misalign_err<=0, all counters<=0
  - branch_taken (regardless of stall):
    - pc<={branch_target[WIDTH-1:2],2'b00}
    - IF/ID<=bubble (instr=NOP_INSTR, valid=0, ifid_pc/pc_plus4 hold)
    - flush_count+=1
    - if branch_target[1:0]!=0, misalign_err<=1
  - stall:
    - pc, IF/ID and ifid_valid hold
    - stall_count+=1
  - normal:
    - ifid_pc<=pc, ifid_pc_plus4<=pc+4, ifid_instr<=imem_data, ifid_valid<=1
    - pc<=pc+4, fetch_count+=1
- Arithmetic: pc+4 and all counters wrap modulo 2^width. No saturation.
- misalign_err stays set until rst.
- The flushed fetch address is discarded. The redirected fetch is issued the cycle after branch_taken.

## Timing
- Reset values:
  - imem_addr=RESET_PC, ifid_instr=NOP_INSTR, ifid_valid=0
  - ifid_pc=0, ifid_pc_plus4=0, misalign_err=0, counters=0
- Fetch latency: the word at address A, presented on imem_addr in cycle n, appears on ifid_instr/ifid_pc=A after edge n+1.
- Steady-state throughput is one instruction per cycle.
- Stall: each cycle stall=1 (and branch_taken=0), imem_addr and IF/ID are identical before and after the edge.
- Redirect: one bubble cycle (ifid_valid=0) after branch_taken. Target instruction is valid in IF/ID one cycle later.
- Simultaneous stall+branch_taken: redirect wins and stall_count is unchanged.
- rst asserted mid-operation (any stall/branch state): reset values apply after that edge. The first fetch after deassertion is at RESET_PC.
- imem_data is combinational and returns NOP while rst=1. It is captured only on normal edges.

## Test plan
- Reset/free run:
  - Stimulus: rst=1 two cycles, then 0. Memory holds 00A00093, 00508133, 000101B3.
  - Response: imem_addr 0,4,8,C on successive cycles. ifid_pc 0,4,8 with matching words, ifid_valid=1, ifid_pc_plus4=4,8,C. fetch_count=3 after third load.
- Stall:
  - Stimulus: stall=1 for one cycle while pc=8.
  - Response: imem_addr=8 for two cycles. ifid_pc=4 held. stall_count=1. Next edge ifid_pc=8.
- Redirect:
  - Stimulus: branch_taken=1, branch_target=0xC while pc=8.
  - Response: next cycle imem_addr=0xC, ifid_valid=0, ifid_instr=00000013, flush_count=1. Following cycle ifid_pc=0xC, valid=1.
- Collision:
  - Stimulus: stall=1 and branch_taken=1 (target 0x40) same cycle.
  - Response: pc=0x40, bubble in IF/ID, stall_count unchanged, flush_count+1.
- Misaligned target:
  - Stimulus: branch_target=0x16.
  - Response: imem_addr=0x14, misalign_err=1. It remains 1 across later normal fetches until rst.
- Reset mid-run:
  - Stimulus: rst=1 at pc=0x20 with stall=1.
  - Response: next cycle imem_addr=RESET_PC, ifid_valid=0, all counters 0, misalign_err=0.
